// File: rtl/register_sequencer.sv
// Initiator for an NBits register's funsel/e/i control port: loads a start value, steps it
// toward a target one count per cycle, optionally clears it, then pulses done.
module register_sequencer #(
  parameter int unsigned NBits = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBits-1:0] start_val,
  input  logic [NBits-1:0] end_val,
  input  logic             clear_after,
  input  logic             abort,
  input  logic [NBits-1:0] q,
  output logic [1:0]       funsel,
  output logic             e,
  output logic [NBits-1:0] i,
  output logic             busy,
  output logic             done,
  output logic [NBits-1:0] step_count
);

  localparam logic [1:0] FunClear = 2'b00;
  localparam logic [1:0] FunLoad  = 2'b01;
  localparam logic [1:0] FunDec   = 2'b10;
  localparam logic [1:0] FunInc   = 2'b11;

  typedef enum logic [2:0] {StIdle, StLoad, StStep, StClear, StDone} state_e;

  state_e           state_q, state_d;
  logic [NBits-1:0] start_val_q, start_val_d;
  logic [NBits-1:0] end_val_q, end_val_d;
  logic             clear_after_q, clear_after_d;
  logic [NBits-1:0] step_count_q, step_count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      start_val_q   <= '0;
      end_val_q     <= '0;
      clear_after_q <= 1'b0;
      step_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      start_val_q   <= start_val_d;
      end_val_q     <= end_val_d;
      clear_after_q <= clear_after_d;
      step_count_q  <= step_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    start_val_d   = start_val_q;
    end_val_d     = end_val_q;
    clear_after_d = clear_after_q;
    step_count_d  = step_count_q;
    e             = 1'b0;
    funsel        = FunClear;
    busy          = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          start_val_d   = start_val;
          end_val_d     = end_val;
          clear_after_d = clear_after;
          step_count_d  = '0;
          state_d       = StLoad;
        end
      end
      StLoad: begin
        busy    = 1'b1;
        e       = 1'b1;
        funsel  = FunLoad;
        state_d = abort ? StIdle : StStep;
      end
      StStep: begin
        busy = 1'b1;
        // Direction comes straight from q, so the register never wraps during a command.
        if (q < end_val_q) begin
          e            = 1'b1;
          funsel       = FunInc;
          step_count_d = step_count_q + NBits'(1);
        end else if (q > end_val_q) begin
          e            = 1'b1;
          funsel       = FunDec;
          step_count_d = step_count_q + NBits'(1);
        end else begin
          state_d = clear_after_q ? StClear : StDone;
        end
        if (abort) state_d = StIdle;
      end
      StClear: begin
        busy    = 1'b1;
        e       = 1'b1;
        funsel  = FunClear;
        state_d = abort ? StIdle : StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign i          = start_val_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_register_sequencer.sv
// Bench for register_sequencer: a behavioural NBits register closes the loop; expected
// results are queued as commands are issued and popped when done is observed.
module tb_register_sequencer;

  localparam int unsigned NBits = 4;

  logic             clk = 1'b0;
  logic             rst, start, clear_after, abort;
  logic [NBits-1:0] start_val, end_val, i, step_count;
  logic [NBits-1:0] q = '0;
  logic [1:0]       funsel;
  logic             e, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  register_sequencer #(.NBits(NBits)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_val  (start_val),
    .end_val    (end_val),
    .clear_after(clear_after),
    .abort      (abort),
    .q          (q),
    .funsel     (funsel),
    .e          (e),
    .i          (i),
    .busy       (busy),
    .done       (done),
    .step_count (step_count)
  );

  // Responder register model.
  always @(posedge clk) begin
    if (e) begin
      case (funsel)
        2'b00:   q <= '0;
        2'b01:   q <= i;
        2'b10:   q <= q - 1'b1;
        default: q <= q + 1'b1;
      endcase
    end
  end

  typedef struct {
    logic [NBits-1:0] sv;
    logic [NBits-1:0] ev;
    logic             ca;
    int               done_cyc;
    int               steps;
    int               qf;
    int               n_inc;
    int               n_dec;
    int               n_clr;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    vec_t             x;
    int               inc = 0;
    int               dec = 0;
    int               clr = 0;
    int               dc = -1;
    logic [NBits-1:0] qd = '0;
    logic [NBits-1:0] sc = '0;
    sb.push_back(v);
    @(negedge clk);
    start_val   = v.sv;
    end_val     = v.ev;
    clear_after = v.ca;
    start       = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin
        check("load_funsel", 32'(funsel), 32'd1);
        check("load_e", 32'(e), 32'd1);
        check("load_i", 32'(i), 32'(v.sv));
        check("load_busy", 32'(busy), 32'd1);
        start_val = ~v.sv;  // i must hold the latched value
        end_val   = ~v.ev;
      end else if (e) begin
        case (funsel)
          2'b11:   inc++;
          2'b10:   dec++;
          2'b00:   clr++;
          default: ;
        endcase
      end
      if (done) begin
        dc = c;
        qd = q;
        sc = step_count;
        break;
      end
    end
    x = sb.pop_front();
    check("done_cycle", 32'(dc), 32'(x.done_cyc));
    check("step_count", 32'(sc), 32'(x.steps));
    check("q_final", 32'(qd), 32'(x.qf));
    check("inc_cycles", 32'(inc), 32'(x.n_inc));
    check("dec_cycles", 32'(dec), 32'(x.n_dec));
    check("clear_cycles", 32'(clr), 32'(x.n_clr));
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{4'h1, 4'h5, 1'b0,  7,  4, 5,  4, 0, 0};
    vecs[1] = '{4'hF, 4'hC, 1'b1,  7,  3, 0,  0, 3, 1};
    vecs[2] = '{4'hA, 4'hA, 1'b0,  3,  0, 10, 0, 0, 0};
    vecs[3] = '{4'h0, 4'hF, 1'b0, 18, 15, 15, 15, 0, 0};
    vecs[4] = '{4'h9, 4'h2, 1'b0, 10,  7, 2,  0, 7, 0};
    vecs[5] = '{4'h3, 4'h6, 1'b1,  7,  3, 0,  3, 0, 1};

    rst = 1'b1; start = 1'b1; abort = 1'b1; clear_after = 1'b0;
    start_val = 4'h7; end_val = 4'h9;
    repeat (2) @(negedge clk);
    check("rst_e", 32'(e), 32'd0);
    check("rst_funsel", 32'(funsel), 32'd0);
    check("rst_i", 32'(i), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_step_count", 32'(step_count), 32'd0);
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 6; n++) run_cmd(vecs[n]);

    // Abort in the third STEP cycle of 0 -> 15; a start raised while busy is ignored.
    @(negedge clk);
    start_val = 4'h0; end_val = 4'hF; clear_after = 1'b0; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = (c == 2);
      if (c == 4) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_e", 32'(e), 32'd0);
    check("abort_step_count", 32'(step_count), 32'd3);
    begin
      int seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check("abort_no_done", 32'(seen), 32'd0);
    end
    check("abort_q_frozen", 32'(q), 32'd3);

    // Synchronous reset during STEP.
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_e", 32'(e), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_step_count", 32'(step_count), 32'd0);
    check("rst_mid_i", 32'(i), 32'd0);
    begin
      int seen = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (done || busy) seen++;
      end
      check("rst_mid_no_done", 32'(seen), 32'd0);
    end
    run_cmd(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
